// File: rtl/conv_mac_pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared definitions for the convolution MAC processing element:
//            the PE mode encodings, default widths and the tap-counter
//            width helper.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [1:0] {
    PE_IDLE   = 2'd0,
    PE_MAC    = 2'd1,
    PE_CLEAR  = 2'd2,
    PE_BYPASS = 2'd3
  } pe_mode_e;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int TAPS_DEF   = 9;

  // A one-tap window still needs a 1-bit counter to hold a legal width.
  function automatic int cnt_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  localparam int TAP_CNT_W = cnt_width(TAPS_DEF);

endpackage
`default_nettype wire

// File: rtl/conv_mac_pe_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_pe_if
// Purpose  : Sequencer <-> PE bundle.
//            Operand side : pe_mode, in_valid, in_data, in_filter, in_ready
//            Result side  : out_valid, out_ready, pe_output, out_acc
//            Status       : sat_flag, busy
//            master = sequencer, slave = processing element.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_mac_pe_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  pe_mode_e            pe_mode;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic [DATA_W-1:0]   in_filter;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   pe_output;
  logic [ACC_W-1:0]    out_acc;
  logic                sat_flag;
  logic                busy;

  modport master (
    output pe_mode, in_valid, in_data, in_filter, out_ready,
    input  in_ready, out_valid, pe_output, out_acc, sat_flag, busy
  );

  modport slave (
    input  pe_mode, in_valid, in_data, in_filter, out_ready,
    output in_ready, out_valid, pe_output, out_acc, sat_flag, busy
  );

endinterface
`default_nettype wire

// File: rtl/conv_mac_pe_sat_shift.sv
`default_nettype none
// ============================================================================
// Module   : pe_sat_shift
// Purpose  : Combinational result formatter. Right-shifts the accumulator by
//            SHIFT and saturates the unsigned value to DATA_W bits.
// Ports    : acc_in [ACC_W]  - accumulator value
//            result [DATA_W] - shifted, saturated result
//            sat             - high when saturation clipped the value
// Revision : 1.0 - initial release
// ============================================================================
module pe_sat_shift #(
  parameter int ACC_W  = 20,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 0
) (
  input  wire [ACC_W-1:0]  acc_in,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  logic [ACC_W-1:0] shifted;

  assign shifted = acc_in >> SHIFT;

  generate
    if (ACC_W > DATA_W) begin : g_wide
      // Any set bit above the result width means the value does not fit.
      assign sat    = |shifted[ACC_W-1:DATA_W];
      assign result = sat ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
    end else begin : g_narrow
      assign sat    = 1'b0;
      assign result = DATA_W'(shifted);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/conv_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_pe
// Purpose  : Multiply-accumulate processing element. Accepts one data/filter
//            pair per cycle, accumulates TAPS products per window through a
//            multiply stage and an accumulate stage, and returns one
//            shifted/saturated result per window. An unconsumed result stalls
//            the whole pipeline.
// Ports    : clk, rst (async, active-high)
//            pe (slave) - operand handshake, result handshake, status
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_pe
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int SHIFT  = 0
) (
  input wire            clk,
  input wire            rst,
  conv_mac_pe_if.slave  pe
);

  localparam int              CNT_W    = cnt_width(TAPS);
  localparam int              PROD_W   = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic               en;
  logic               mode_ok;
  logic               accept;
  logic               is_mac;
  logic               is_bypass;
  logic               is_clear;
  logic               completing;

  logic [CNT_W-1:0]   tap_cnt;
  logic               s1_valid;
  logic               s1_first;
  logic               s1_last;
  logic [PROD_W-1:0]  s1_prod;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [DATA_W-1:0]  sat_result;
  logic               sat_hit;

  logic               res_valid;
  logic [DATA_W-1:0]  res_data;
  logic [ACC_W-1:0]   res_acc;
  logic               sat_sticky;

  assign is_mac    = (pe.pe_mode == PE_MAC);
  assign is_bypass = (pe.pe_mode == PE_BYPASS);
  assign is_clear  = (pe.pe_mode == PE_CLEAR);

  // A held result that nobody takes freezes every pipeline register.
  assign en = !(res_valid && !pe.out_ready);

  // Bypass may only enter an empty pipeline so it never splits a window.
  always_comb begin
    mode_ok = 1'b0;
    case (pe.pe_mode)
      PE_MAC:    mode_ok = 1'b1;
      PE_BYPASS: mode_ok = (tap_cnt == '0) && !s1_valid;
      default:   mode_ok = 1'b0;
    endcase
  end

  assign pe.in_ready = en && mode_ok;
  assign accept      = pe.in_valid && pe.in_ready;

  // Stage 1: multiply (or pass data through) and tag window boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (is_clear) begin
      tap_cnt  <= '0;
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_prod  <= is_bypass ? PROD_W'(pe.in_data)
                            : PROD_W'(pe.in_data) * PROD_W'(pe.in_filter);
      s1_first <= (tap_cnt == '0) || is_bypass;
      s1_last  <= (tap_cnt == LAST_TAP) || is_bypass;
      if (accept && is_mac) begin
        tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
      end
    end
  end

  // Stage 2: accumulate; the first tap of a window restarts from zero.
  assign acc_next   = (s1_first ? '0 : acc) + ACC_W'(s1_prod);
  // A clear discards the in-flight product, so it never completes a window.
  assign completing = en && s1_valid && s1_last && !is_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (is_clear) begin
      acc <= '0;
    end else if (en && s1_valid) begin
      acc <= acc_next;
    end
  end

  pe_sat_shift #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_sat_shift (
    .acc_in (acc_next),
    .result (sat_result),
    .sat    (sat_hit)
  );

  // Result register: a completing window wins over a same-cycle consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_acc    <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (completing) begin
        res_valid <= 1'b1;
        res_data  <= sat_result;
        res_acc   <= acc_next;
      end else if (res_valid && pe.out_ready) begin
        res_valid <= 1'b0;
      end

      if (is_clear) begin
        sat_sticky <= 1'b0;
      end else if (completing && sat_hit) begin
        sat_sticky <= 1'b1;
      end
    end
  end

  assign pe.out_valid = res_valid;
  assign pe.pe_output = res_data;
  assign pe.out_acc   = res_acc;
  assign pe.sat_flag  = sat_sticky;
  assign pe.busy      = (tap_cnt != '0) || s1_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mac_pe
// Purpose  : Directed self-checking bench for conv_mac_pe (DATA_W=8,
//            ACC_W=20, TAPS=9, SHIFT=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mac_pe;
  import conv_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  conv_mac_pe_if #(.DATA_W(8), .ACC_W(20)) bus ();

  conv_mac_pe #(
    .DATA_W (8),
    .ACC_W  (20),
    .TAPS   (9),
    .SHIFT  (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pe  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers n taps; in_ready is read 3 time units after an edge so any
  // out_ready change made 1 unit after the edge has already settled.
  task automatic drive_taps(input logic [7:0] d, input logic [7:0] f,
                            input int n, input pe_mode_e m);
    int sent  = 0;
    int guard = 0;
    bus.pe_mode   = m;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_filter = f;
    while (sent < n && guard < 200) begin
      #2;
      if (bus.in_ready) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (sent != n) $display("FAIL drive_taps_accepted: got %0d required %0d", sent, n);
    else passed++;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.pe_mode   = pe_mode_e'($urandom_range(0, 3));
    bus.in_valid  = 1'($urandom);
    bus.in_data   = 8'($urandom);
    bus.in_filter = 8'($urandom);
    bus.out_ready = 1'($urandom);
    repeat (3) step();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'd0) $display("FAIL reset_pe_output: got %0d required 0", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'd0) $display("FAIL reset_out_acc: got %0d required 0", bus.out_acc); else passed++;
    checks++; if (bus.sat_flag !== 1'b0) $display("FAIL reset_sat_flag: got %b required 0", bus.sat_flag); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy); else passed++;
    bus.pe_mode   = PE_IDLE;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready_idle: got %b required 0", bus.in_ready); else passed++;
    bus.pe_mode = PE_MAC;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_mac: got %b required 1", bus.in_ready); else passed++;
    bus.pe_mode = PE_IDLE;
  endtask

  task automatic test_single_window();
    bus.out_ready = 1'b1;
    drive_taps(8'd1, 8'd2, 9, PE_MAC);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid: got %b required 0", bus.out_valid); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_out_valid: got %b required 1", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'd18) $display("FAIL single_pe_output: got %0d required 18", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'd18) $display("FAIL single_out_acc: got %0d required 18", bus.out_acc); else passed++;
    checks++; if (bus.sat_flag !== 1'b0) $display("FAIL single_sat_flag: got %b required 0", bus.sat_flag); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_valid_pulse: got %b required 0", bus.out_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after: got %b required 0", bus.busy); else passed++;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    drive_taps(8'd255, 8'd255, 9, PE_MAC);
    step();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL sat_out_valid: got %b required 1", bus.out_valid); else passed++;
    checks++; if (bus.out_acc !== 20'd585225) $display("FAIL sat_out_acc: got %0d required 585225", bus.out_acc); else passed++;
    checks++; if (bus.pe_output !== 8'd255) $display("FAIL sat_pe_output: got %0d required 255", bus.pe_output); else passed++;
    checks++; if (bus.sat_flag !== 1'b1) $display("FAIL sat_flag_set: got %b required 1", bus.sat_flag); else passed++;
    repeat (3) step();
    checks++; if (bus.sat_flag !== 1'b1) $display("FAIL sat_flag_sticky: got %b required 1", bus.sat_flag); else passed++;
    bus.pe_mode = PE_CLEAR;
    step();
    bus.pe_mode = PE_IDLE;
    checks++; if (bus.sat_flag !== 1'b0) $display("FAIL sat_flag_cleared: got %b required 0", bus.sat_flag); else passed++;
    checks++; if (bus.out_acc !== 20'd585225) $display("FAIL sat_clear_keeps_out_acc: got %0d required 585225", bus.out_acc); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    fork
      begin
        drive_taps(8'd2, 8'd3, 9, PE_MAC);
        drive_taps(8'd1, 8'd1, 9, PE_MAC);
      end
      begin
        int g = 0;
        while (!bus.out_valid && g < 100) begin
          step();
          g++;
        end
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b required 1", bus.out_valid); else passed++;
        checks++; if (bus.pe_output !== 8'd54) $display("FAIL b2b_first_output: got %0d required 54", bus.pe_output); else passed++;
        repeat (3) step();
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready: got %b required 0", bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_stall_valid: got %b required 1", bus.out_valid); else passed++;
        checks++; if (bus.pe_output !== 8'd54) $display("FAIL b2b_stall_output: got %0d required 54", bus.pe_output); else passed++;
        checks++; if (bus.out_acc !== 20'd54) $display("FAIL b2b_stall_out_acc: got %0d required 54", bus.out_acc); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_stall_busy: got %b required 1", bus.busy); else passed++;
        bus.out_ready = 1'b1;
      end
    join
    begin
      int g = 0;
      while (!bus.out_valid && g < 20) begin
        step();
        g++;
      end
    end
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b required 1", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'd9) $display("FAIL b2b_second_output: got %0d required 9", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'd9) $display("FAIL b2b_second_out_acc: got %0d required 9", bus.out_acc); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drained_valid: got %b required 0", bus.out_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_drained_busy: got %b required 0", bus.busy); else passed++;
  endtask

  task automatic test_clear_mid_window();
    bus.out_ready = 1'b1;
    drive_taps(8'd5, 8'd5, 4, PE_MAC);
    bus.pe_mode = PE_CLEAR;
    bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL clear_in_ready: got %b required 0", bus.in_ready); else passed++;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL clear_busy: got %b required 0", bus.busy); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL clear_no_result: got %b required 0", bus.out_valid); else passed++;
    drive_taps(8'd3, 8'd3, 9, PE_MAC);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL clear_early_valid: got %b required 0", bus.out_valid); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL clear_out_valid: got %b required 1", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'd81) $display("FAIL clear_pe_output: got %0d required 81", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'd81) $display("FAIL clear_out_acc: got %0d required 81", bus.out_acc); else passed++;
    step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL clear_busy_after: got %b required 0", bus.busy); else passed++;
  endtask

  task automatic test_bypass_and_reset();
    bus.out_ready = 1'b1;
    bus.pe_mode   = PE_BYPASS;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.in_filter = 8'h11;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bypass_in_ready: got %b required 1", bus.in_ready); else passed++;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bypass_early_valid: got %b required 0", bus.out_valid); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL bypass_out_valid: got %b required 1", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'h5A) $display("FAIL bypass_pe_output: got %h required 5a", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'h5A) $display("FAIL bypass_out_acc: got %h required 5a", bus.out_acc); else passed++;

    drive_taps(8'd1, 8'd1, 3, PE_MAC);
    bus.pe_mode = PE_BYPASS;
    bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bypass_blocked_mid_window: got %b required 0", bus.in_ready); else passed++;
    bus.in_valid = 1'b0;
    bus.pe_mode  = PE_MAC;

    // Asynchronous reset pulse well away from any clock edge.
    #1 rst = 1'b1;
    #2;
    checks++; if (bus.busy !== 1'b0) $display("FAIL async_rst_busy: got %b required 0", bus.busy); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL async_rst_out_valid: got %b required 0", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'd0) $display("FAIL async_rst_pe_output: got %0d required 0", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'd0) $display("FAIL async_rst_out_acc: got %0d required 0", bus.out_acc); else passed++;
    rst = 1'b0;
    step();

    drive_taps(8'd4, 8'd7, 9, PE_MAC);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_rst_early_valid: got %b required 0", bus.out_valid); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL post_rst_out_valid: got %b required 1", bus.out_valid); else passed++;
    checks++; if (bus.pe_output !== 8'd252) $display("FAIL post_rst_pe_output: got %0d required 252", bus.pe_output); else passed++;
    checks++; if (bus.out_acc !== 20'd252) $display("FAIL post_rst_out_acc: got %0d required 252", bus.out_acc); else passed++;
    checks++; if (bus.sat_flag !== 1'b0) $display("FAIL post_rst_sat_flag: got %b required 0", bus.sat_flag); else passed++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.pe_mode   = PE_IDLE;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_filter = 8'd0;
    bus.out_ready = 1'b1;

    test_reset();
    test_single_window();
    test_saturation();
    test_back_to_back();
    test_clear_mid_window();
    test_bypass_and_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
